// File: rtl/rv32_hazard_if.sv
// rv32_hazard_if -- bundle between the rv32 pipeline and its hazard controller.
//
// Ports:
//   decode_rs1_in / decode_rs2_in   source registers of the instruction at execute inputs
//   execute_mem_read_in / _rd_in    load flag and rd of the instruction at mem inputs
//   mem_branch_taken_in             mem resolved a taken branch/jump
//   dbus_req_in / dbus_ready_in     data-bus request and completion
//   *_stall_out / *_flush_out       per-stage hold and bubble controls
//   dbus_timeout_out                one-cycle abort pulse toward fetch
//   stall_cycles_out / flush_events_out  performance counters (only with RV32_HAZARD_PERF_EN)
//
// Modports: master = pipeline side, slave = hazard controller.
// Macro: RV32_HAZARD_PERF_EN adds the counter signals, CTR_WIDTH sizes them.
interface rv32_hazard_if #(
    parameter int CTR_WIDTH = 32
);
    logic [4:0] decode_rs1_in;
    logic [4:0] decode_rs2_in;
    logic       execute_mem_read_in;
    logic [4:0] execute_rd_in;
    logic       mem_branch_taken_in;
    logic       dbus_req_in;
    logic       dbus_ready_in;

    logic fetch_stall_out;
    logic decode_stall_out;
    logic execute_stall_out;
    logic mem_stall_out;
    logic fetch_flush_out;
    logic decode_flush_out;
    logic execute_flush_out;
    logic mem_flush_out;
    logic dbus_timeout_out;

`ifdef RV32_HAZARD_PERF_EN
    logic [CTR_WIDTH-1:0] stall_cycles_out;
    logic [CTR_WIDTH-1:0] flush_events_out;
`endif

    modport master (
`ifdef RV32_HAZARD_PERF_EN
        input  stall_cycles_out, flush_events_out,
`endif
        output decode_rs1_in, decode_rs2_in, execute_mem_read_in, execute_rd_in,
               mem_branch_taken_in, dbus_req_in, dbus_ready_in,
        input  fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
               fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out,
               dbus_timeout_out
    );

    modport slave (
`ifdef RV32_HAZARD_PERF_EN
        output stall_cycles_out, flush_events_out,
`endif
        input  decode_rs1_in, decode_rs2_in, execute_mem_read_in, execute_rd_in,
               mem_branch_taken_in, dbus_req_in, dbus_ready_in,
        output fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
               fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out,
               dbus_timeout_out
    );
endinterface

// File: rtl/rv32_hazard.sv
// rv32_hazard -- pipeline hazard controller for the rv32 core.
// Drives stall/flush for fetch, decode, execute and mem from load-use,
// taken-branch and data-bus wait conditions; flushes the pipe for
// FILL_CYCLES after reset and aborts a data-bus access on its
// DBUS_TIMEOUT-th wait cycle.
//
// Ports:
//   clk      clock, posedge
//   reset_n  asynchronous active-low reset
//   hz       rv32_hazard_if.slave (pipeline inputs, stage controls, abort pulse)
//
// Macro: RV32_HAZARD_PERF_EN adds stall-cycle and flush-event counters.
//
// state | meaning
// FILL  | post-reset flush of every stage, inputs ignored
// RUN   | normal operation, no access waiting
// DWAIT | data-bus access has been stalled at least one cycle
module rv32_hazard #(
    parameter int FILL_CYCLES  = 3,
    parameter int DBUS_TIMEOUT = 16
) (
    input logic         clk,
    input logic         reset_n,
    rv32_hazard_if.slave hz
);
    localparam int FW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES + 1) : 1;
    localparam int WW = (DBUS_TIMEOUT > 2) ? $clog2(DBUS_TIMEOUT) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(DBUS_TIMEOUT - 1);

    typedef enum logic [1:0] {FILL, RUN, DWAIT} state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fill_cnt_q, fill_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;

    logic pend, load_use;
    logic stall_fd, stall_em, flush_fde, flush_m, timeout;
    logic stall_evt, flush_evt;

    assign pend     = hz.dbus_req_in & ~hz.dbus_ready_in;
    // No rs-used qualifier: unused operand fields may cause harmless stalls.
    assign load_use = hz.execute_mem_read_in && (hz.execute_rd_in != 5'd0) &&
                      ((hz.execute_rd_in == hz.decode_rs1_in) ||
                       (hz.execute_rd_in == hz.decode_rs2_in));

    always_comb begin
        stall_fd   = 1'b0;
        stall_em   = 1'b0;
        flush_fde  = 1'b0;
        flush_m    = 1'b0;
        timeout    = 1'b0;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            FILL: begin
                flush_fde  = 1'b1;
                flush_m    = 1'b1;
                fill_cnt_d = fill_cnt_q + FW'(1);
                if (fill_cnt_q == FILL_LAST)
                    state_d = RUN;
            end
            default: begin
                // In RUN wait_cnt is 0, so the first wait cycle lands on 1.
                if (pend && (wait_cnt_q != WAIT_LAST)) begin
                    stall_fd   = 1'b1;
                    stall_em   = 1'b1;
                    stall_evt  = 1'b1;
                    state_d    = DWAIT;
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (pend) begin
                        timeout   = 1'b1;
                        flush_fde = 1'b1;
                        flush_m   = 1'b1;
                        flush_evt = 1'b1;
                    end else if (hz.mem_branch_taken_in) begin
                        flush_fde = 1'b1;
                        flush_evt = 1'b1;
                    end else if (load_use) begin
                        // Hold the consumer, drop a bubble into mem.
                        stall_fd  = 1'b1;
                        stall_evt = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign hz.fetch_stall_out   = stall_fd;
    assign hz.decode_stall_out  = stall_fd;
    assign hz.execute_stall_out = stall_em;
    assign hz.mem_stall_out     = stall_em;
    assign hz.fetch_flush_out   = flush_fde;
    assign hz.decode_flush_out  = flush_fde;
    // Load-use bubbles execute's output register without flushing upstream.
    assign hz.execute_flush_out = flush_fde | (stall_fd & ~stall_em);
    assign hz.mem_flush_out     = flush_m;
    assign hz.dbus_timeout_out  = timeout;

`ifdef RV32_HAZARD_PERF_EN
    logic [$bits(hz.stall_cycles_out)-1:0] stall_ctr_q;
    logic [$bits(hz.flush_events_out)-1:0] flush_ctr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_ctr_q <= '0;
            flush_ctr_q <= '0;
        end else begin
            if (stall_evt) stall_ctr_q <= stall_ctr_q + 1'b1;
            if (flush_evt) flush_ctr_q <= flush_ctr_q + 1'b1;
        end
    end

    assign hz.stall_cycles_out = stall_ctr_q;
    assign hz.flush_events_out = flush_ctr_q;
`endif
endmodule
